// File: rtl/pp_pkg.sv
// Shared PeriPlex definitions: frame/byte widths common with uart_packetizer
// and the serializer state encoding.
package pp_pkg;

    localparam int unsigned RAH_FRAME_WIDTH = 48;
    localparam int unsigned UART_BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        WAIT  = 3'd3,
        GAP   = 3'd4
    } pp_state_t;

endpackage

// File: rtl/pp_down_counter.sv
// Loadable down-counter that saturates at zero; zero flags the final count
// of a FETCH latency or GAP interval.
module pp_down_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pp_frame_serializer.sv
// Pops one RAH frame from the egress FIFO and sends it MSB byte first as
// single-byte transfers to the UART transmitter.
module pp_frame_serializer
    import pp_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH     = RAH_FRAME_WIDTH,
    parameter int unsigned BYTE_WIDTH      = UART_BYTE_WIDTH,
    parameter int unsigned FIFO_RD_LATENCY = 1,
    parameter int unsigned GAP_CYCLES      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   f_empty,
    output logic                   rd_en,
    input  logic [FRAME_WIDTH-1:0] data,
    input  logic                   tx_done,
    output logic                   tx_dv,
    output logic [BYTE_WIDTH-1:0]  tx_byte,
    output logic                   busy,
    output logic [7:0]             frame_cnt
);

    localparam int unsigned NBYTES = FRAME_WIDTH / BYTE_WIDTH;
    localparam int unsigned IDX_W  = $clog2(NBYTES);
    localparam int unsigned CNT_W  = 8;

    // Counter terminates on zero, so each interval loads its length minus one.
    localparam logic [CNT_W-1:0] FETCH_LOAD = CNT_W'(FIFO_RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NBYTES - 1);

    pp_state_t              state, state_nx;
    logic [FRAME_WIDTH-1:0] shreg, shreg_nx;
    logic [IDX_W-1:0]       idx, idx_nx;
    logic                   rd_en_nx;
    logic                   tx_dv_nx;
    logic [BYTE_WIDTH-1:0]  tx_byte_nx;
    logic                   busy_nx;
    logic [7:0]             frame_cnt_nx;

    logic                   cnt_load;
    logic [CNT_W-1:0]       cnt_load_val;
    logic                   cnt_en;
    logic                   cnt_zero;

    pp_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nx     = state;
        shreg_nx     = shreg;
        idx_nx       = idx;
        rd_en_nx     = 1'b0;
        tx_dv_nx     = 1'b0;
        tx_byte_nx   = tx_byte;
        frame_cnt_nx = frame_cnt;
        cnt_load     = 1'b0;
        cnt_load_val = FETCH_LOAD;
        cnt_en       = 1'b0;

        unique case (state)
            IDLE: begin
                if (!f_empty) begin
                    rd_en_nx     = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = FETCH_LOAD;
                    state_nx     = FETCH;
                end
            end
            FETCH: begin
                if (cnt_zero) begin
                    shreg_nx = data;
                    idx_nx   = '0;
                    state_nx = SEND;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            SEND: begin
                tx_dv_nx   = 1'b1;
                tx_byte_nx = shreg[FRAME_WIDTH-1 -: BYTE_WIDTH];
                state_nx   = WAIT;
            end
            WAIT: begin
                // tx_done outside WAIT falls through the other arms untouched.
                if (tx_done) begin
                    shreg_nx = shreg << BYTE_WIDTH;
                    idx_nx   = idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        frame_cnt_nx = frame_cnt + 8'd1;
                        if (GAP_CYCLES == 0) begin
                            state_nx = IDLE;
                        end else begin
                            cnt_load     = 1'b1;
                            cnt_load_val = GAP_LOAD;
                            state_nx     = GAP;
                        end
                    end else begin
                        state_nx = SEND;
                    end
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_nx = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            idx       <= '0;
            rd_en     <= 1'b0;
            tx_dv     <= 1'b0;
            tx_byte   <= '0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            idx       <= idx_nx;
            rd_en     <= rd_en_nx;
            tx_dv     <= tx_dv_nx;
            tx_byte   <= tx_byte_nx;
            busy      <= busy_nx;
            frame_cnt <= frame_cnt_nx;
        end
    end

endmodule
